// File: rtl/vga_code_mailbox_if.sv
// CPU bus bundle for the VGA code mailbox: one-cycle select/write strobe,
// 2-bit register address, 32-bit write data and registered read data.
interface vga_code_mailbox_if;
  logic        cs;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output cs,
    output we,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  cs,
    input  we,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/vga_code_mailbox.sv
// Shadow/active display-code mailbox feeding the VGA controller. New codes
// commit at the start of vertical sync; frames are counted and can raise an IRQ.
module vga_code_mailbox #(
  parameter int FRAME_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  vga_code_mailbox_if.slave   bus,
  input  logic                v_sync,
  output logic [31:0]         code,
  output logic                irq
);

  localparam logic [1:0] ADDR_SHADOW = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_FRAME  = 2'd2;
  localparam logic [1:0] ADDR_ACTIVE = 2'd3;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic               s1;
  logic               s2;
  logic               s3;
  logic               frame_tick;
  logic [31:0]        shadow;
  logic               imm;
  logic               irq_en;
  logic [0:0]         state;
  logic               pending;
  logic [FRAME_W-1:0] frame;
  logic               wr;
  logic               rd;
  logic               shadow_wr;
  logic               ctrl_wr;
  logic               frame_wr;
  logic [31:0]        frame_ext;
  logic [31:0]        rd_mux;

  assign wr        = bus.cs & bus.we;
  assign rd        = bus.cs & ~bus.we;
  assign shadow_wr = wr & (bus.addr == ADDR_SHADOW);
  assign ctrl_wr   = wr & (bus.addr == ADDR_CTRL);
  assign frame_wr  = wr & (bus.addr == ADDR_FRAME);

  // Falling edge of the synchronised active-low v_sync.
  assign frame_tick = s3 & ~s2;
  assign pending    = (state == ST_PENDING);
  assign frame_ext  = 32'(frame);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= v_sync;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm    <= 1'b0;
      irq_en <= 1'b0;
    end else if (ctrl_wr) begin
      imm    <= bus.wdata[0];
      irq_en <= bus.wdata[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= 32'd0;
    end else if (shadow_wr) begin
      shadow <= bus.wdata;
    end
  end

  // A write landing on the tick edge is committed straight away so fresh data
  // is never held back a whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code <= 32'd0;
    end else if (shadow_wr && (imm || frame_tick)) begin
      code <= bus.wdata;
    end else if (frame_tick && pending) begin
      code <= shadow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (shadow_wr && !imm && !frame_tick) state <= ST_PENDING;
        end
        ST_PENDING: begin
          if (frame_tick || (shadow_wr && imm)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame <= '0;
    end else if (frame_tick) begin
      frame <= frame + FRAME_W'(1);
    end
  end

  // Setting has priority over a FRAME-write clear so no tick is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (frame_tick && irq_en) begin
      irq <= 1'b1;
    end else if (frame_wr) begin
      irq <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (bus.addr)
      ADDR_SHADOW: rd_mux = shadow;
      ADDR_CTRL:   rd_mux = {29'd0, pending, irq_en, imm};
      ADDR_FRAME:  rd_mux = frame_ext;
      ADDR_ACTIVE: rd_mux = code;
      default:     rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rdata <= 32'd0;
    end else if (rd) begin
      bus.rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_vga_code_mailbox.sv
// Self-checking bench for vga_code_mailbox: directed scenarios plus randomized
// bus/v_sync traffic against a transaction-level model of the mailbox.
module tb_vga_code_mailbox;
  // Narrow frame counter keeps the wrap-around scenario short.
  localparam int FW = 10;
  localparam int FMAX = (1 << FW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v_sync = 1'b1;
  logic [31:0] code;
  logic        irq;

  vga_code_mailbox_if bus ();

  vga_code_mailbox #(.FRAME_W(FW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .v_sync (v_sync),
    .code   (code),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_shadow, m_code;
  bit          m_pending, m_imm, m_irq_en, m_irq;
  int          m_frame;

  function automatic void model_reset();
    m_shadow = 0; m_code = 0; m_pending = 0; m_imm = 0;
    m_irq_en = 0; m_irq = 0; m_frame = 0;
  endfunction

  function automatic void model_write(input logic [1:0] a, input logic [31:0] d);
    case (a)
      2'd0: begin
        m_shadow = d;
        if (m_imm) begin m_code = d; m_pending = 0; end
        else m_pending = 1;
      end
      2'd1: begin m_imm = d[0]; m_irq_en = d[1]; end
      2'd2: m_irq = 0;
      default: ;
    endcase
  endfunction

  function automatic void model_frame();
    m_frame = (m_frame + 1) % (FMAX + 1);
    if (m_pending) begin m_code = m_shadow; m_pending = 0; end
    if (m_irq_en) m_irq = 1;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0: return m_shadow;
      2'd1: return {29'd0, m_pending, m_irq_en, m_imm};
      2'd2: return 32'(m_frame);
      default: return m_code;
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.cs = 1; bus.we = 1; bus.addr = a; bus.wdata = d;
    cycle();
    bus.cs = 0; bus.we = 0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.cs = 1; bus.we = 0; bus.addr = a;
    cycle();
    bus.cs = 0;
    d = bus.rdata;
  endtask

  task automatic vsync_pulse(input int len);
    v_sync = 0;
    repeat (len) cycle();
    v_sync = 1;
    repeat (3) cycle();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1;
    repeat (3) cycle();
    rst = 0;
    cycle();
    model_reset();
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL reset_read%0d: got %h want 00000000", a, d); end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    checks++;
    if (code !== 32'd0) begin errors++; $display("FAIL reset_code: got %h want 00000000", code); end
  endtask

  task automatic test_deferred();
    logic [31:0] d;
    bus_write(2'd0, 32'h12345678); model_write(2'd0, 32'h12345678);
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL deferred_pending: got %h want 00000004", d); end
    checks++;
    if (code !== 32'd0) begin errors++; $display("FAIL deferred_hold: got %h want 00000000", code); end
    v_sync = 0;
    cycle(); cycle();
    checks++;
    if (code !== 32'd0) begin errors++; $display("FAIL deferred_early: got %h want 00000000 after N+1", code); end
    cycle();
    model_frame();
    checks++;
    if (code !== 32'h12345678) begin errors++; $display("FAIL deferred_commit: got %h want 12345678 after N+2", code); end
    v_sync = 1;
    repeat (3) cycle();
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL deferred_frame: got %h want 00000001", d); end
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL deferred_cleared: got %h want 00000000", d); end
  endtask

  task automatic test_immediate();
    logic [31:0] d;
    bus_write(2'd1, 32'h1); model_write(2'd1, 32'h1);
    bus_write(2'd0, 32'hCAFEBABE); model_write(2'd0, 32'hCAFEBABE);
    checks++;
    if (code !== 32'hCAFEBABE) begin errors++; $display("FAIL imm_code: got %h want cafebabe", code); end
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL imm_ctrl: got %h want 00000001", d); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    bus_write(2'd1, 32'h0); model_write(2'd1, 32'h0);
    bus_write(2'd0, 32'h11111111); model_write(2'd0, 32'h11111111);
    v_sync = 0;
    cycle(); cycle();
    bus.cs = 1; bus.we = 1; bus.addr = 2'd0; bus.wdata = 32'hA5A5A5A5;
    cycle();
    bus.cs = 0; bus.we = 0;
    model_frame();
    m_shadow = 32'hA5A5A5A5; m_code = 32'hA5A5A5A5; m_pending = 0;
    checks++;
    if (code !== 32'hA5A5A5A5) begin errors++; $display("FAIL collide_code: got %h want a5a5a5a5", code); end
    v_sync = 1;
    repeat (3) cycle();
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL collide_pending: got %h want 00000000", d); end
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'hA5A5A5A5) begin errors++; $display("FAIL collide_shadow: got %h want a5a5a5a5", d); end
  endtask

  task automatic test_ctrl_no_flush();
    logic [31:0] d;
    bus_write(2'd0, 32'h5555AAAA); model_write(2'd0, 32'h5555AAAA);
    bus_write(2'd1, 32'h1); model_write(2'd1, 32'h1);
    checks++;
    if (code !== 32'hA5A5A5A5) begin errors++; $display("FAIL noflush_code: got %h want a5a5a5a5", code); end
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h5) begin errors++; $display("FAIL noflush_ctrl: got %h want 00000005", d); end
    vsync_pulse(2); model_frame();
    checks++;
    if (code !== 32'h5555AAAA) begin errors++; $display("FAIL noflush_commit: got %h want 5555aaaa", code); end
  endtask

  task automatic test_irq();
    bus_write(2'd1, 32'h2); model_write(2'd1, 32'h2);
    vsync_pulse(1); model_frame();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq); end
    bus_write(2'd2, 32'h0); model_write(2'd2, 32'h0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
    v_sync = 0;
    cycle(); cycle();
    bus.cs = 1; bus.we = 1; bus.addr = 2'd2; bus.wdata = 32'h0;
    cycle();
    bus.cs = 0; bus.we = 0;
    model_write(2'd2, 32'h0); model_frame();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b want 1", irq); end
    v_sync = 1;
    repeat (3) cycle();
    bus_write(2'd2, 32'h0); model_write(2'd2, 32'h0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear2: got %b want 0", irq); end
  endtask

  task automatic test_read_hold();
    logic [31:0] d;
    bus_read(2'd3, d);
    bus.addr = 2'd0;
    repeat (2) cycle();
    bus_write(2'd3, 32'hDEADBEEF); model_write(2'd3, 32'hDEADBEEF);
    checks++;
    if (bus.rdata !== m_code) begin errors++; $display("FAIL read_hold: got %h want %h", bus.rdata, m_code); end
    bus_read(2'd3, d);
    checks++;
    if (d !== m_code) begin errors++; $display("FAIL active_ro: got %h want %h", d, m_code); end
  endtask

  task automatic test_random();
    logic [31:0] d, w;
    logic [1:0]  a;
    int          op;
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 4));
      a = 2'($urandom_range(0, 3));
      w = $urandom;
      case (op)
        0: begin bus_write(2'd0, w); model_write(2'd0, w); end
        1: begin bus_write(2'd1, w); model_write(2'd1, w); end
        2: begin bus_write(a, w); model_write(a, w); end
        3: vsync_pulse_model(int'($urandom_range(1, 6)));
        default: begin
          bus_read(a, d);
          checks++;
          if (d !== model_read(a)) begin errors++; $display("FAIL rand_read[%0d] a=%0d: got %h want %h", i, a, d, model_read(a)); end
        end
      endcase
      checks++;
      if (code !== m_code || irq !== m_irq)
        begin errors++; $display("FAIL rand_out[%0d]: got code=%h irq=%b want code=%h irq=%b", i, code, irq, m_code, m_irq); end
    end
  endtask

  task automatic vsync_pulse_model(input int len);
    vsync_pulse(len);
    model_frame();
  endtask

  task automatic test_async_reset();
    bus_write(2'd1, 32'h2); model_write(2'd1, 32'h2);
    bus_write(2'd0, 32'h77770000); model_write(2'd0, 32'h77770000);
    vsync_pulse(1); model_frame();
    bus_write(2'd0, 32'h0000BEEF); model_write(2'd0, 32'h0000BEEF);
    #2 rst = 1;
    #1;
    checks++;
    if (code !== 32'd0 || irq !== 1'b0)
      begin errors++; $display("FAIL async_reset: got code=%h irq=%b want 00000000/0", code, irq); end
    cycle();
    rst = 0;
    model_reset();
    cycle();
    test_reset_ctrl_read();
  endtask

  task automatic test_reset_ctrl_read();
    logic [31:0] d;
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL async_pending: got %h want 00000000", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    int n;
    n = FMAX - m_frame;
    for (int i = 0; i < n; i++) vsync_pulse_model(1);
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'(FMAX)) begin errors++; $display("FAIL wrap_max: got %h want %h", d, 32'(FMAX)); end
    vsync_pulse_model(1);
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL wrap_zero: got %h want 00000000", d); end
    vsync_pulse_model(800);
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL long_pulse: got %h want 00000001", d); end
  endtask

  initial begin
    bus.cs = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
    model_reset();
    test_reset();
    test_deferred();
    test_immediate();
    test_collision();
    test_ctrl_no_flush();
    test_irq();
    test_read_hold();
    test_random();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_code_mailbox.md
# vga_code_mailbox

CPU-side peripheral that sits directly upstream of the VGA controller and drives its 32-bit `code` input. The CPU writes a new display code into a shadow register. The block commits it to the active `code` output only at the start of vertical sync, so a frame is never drawn with mixed codes. It also counts frames and raises an optional per-frame interrupt, so game software can pace itself to the display.

## Interface
Parameters:
- `FRAME_W`, default 16: width of the frame counter.

Ports:
- `clk`  in  1: system clock, the same clock that feeds the VGA controller.
- `rst`  in  1: asynchronous, active-high reset.
- `cs`  in  1: chip select for a bus access this cycle.
- `we`  in  1: 1 = write, 0 = read (qualified by `cs`).
- `addr`  in  2: register select.
- `wdata`  in  32: write data.
- `rdata`  out  32: registered read data.
- `v_sync`  in  1: V_SYNC from the VGA controller, active-low.
- `code`  out  32: active display code driven to the VGA controller.
- `irq`  out  1: frame interrupt, level, active-high.

## Operation
- Register map:
  - 0 SHADOW: RW.
  - 1 CTRL: bit0 `imm`, bit1 `irq_en`, RW. Reads also return the `pending` flag in bit2.
  - 2 FRAME: reads return the zero-extended frame count. Any write clears `irq`.
  - 3 ACTIVE: read-only, returns `code`. Writes are ignored.
- Write to SHADOW:
  - `shadow <= wdata`.
  - If `imm`=0, set `pending`.
  - If `imm`=1, also `code <= wdata` on the same edge and leave `pending` at 0.
- `v_sync` synchronizer:
  - Passes through flops `s1`→`s2`→`s3`.
  - All three reset to 1, so there is no spurious edge after reset.
- `frame_tick` = `s3 & ~s2` (falling edge of `v_sync`).
- On a clock edge where `frame_tick`=1:
  - `frame <= frame + 1`, wrapping from all-ones to 0.
  - If `pending`: `code <= shadow` and `pending <= 0`.
  - If `irq_en`: `irq <= 1`.
- Pending state machine:
  - IDLE (`pending`=0) goes to PENDING on a SHADOW write with `imm`=0.
  - PENDING goes to IDLE on `frame_tick`.
  - A further SHADOW write while in PENDING overwrites `shadow`; the last write wins.
- Simultaneous SHADOW write and `frame_tick`:
  - `code <= wdata`, `pending <= 0`, independent of `imm`.
  - The fresh data is committed and never delayed a frame.
- Simultaneous `irq` set and FRAME write: set wins, and `irq` stays 1.
- Writing CTRL with `imm`=1 while `pending`=1 does not flush the shadow. The value still commits at the next `frame_tick`.
- Read: `rdata <= selected register` when `cs & ~we`. Otherwise `rdata` holds its last value.

## Timing
- Reset values:
  - `code`, `shadow`, `rdata`, and `frame` are 0.
  - `ctrl`, `pending`, and `irq` are 0.
  - `s1`, `s2`, `s3` are 1.
- Read latency is 1 cycle: `rdata` is valid after the edge that samples `cs & ~we`.
- Write latency:
  - A register updates on the sampling edge.
  - With `imm`=1, `code` changes on that same edge.
- Frame commit latency:
  - Let `v_sync` first be sampled low at edge N.
  - `s1`=0 after N, `s2`=0 after N+1, and `frame_tick` is high during cycle N+1→N+2.
  - `code`, `frame`, and `irq` update on edge N+2.
- Exactly one `frame_tick` per `v_sync` low pulse, regardless of pulse length, provided the pulse is ≥1 clk.
- Asserting `rst` mid-operation immediately forces all reset values, including clearing `pending`, with no dependence on `clk`.

## Test plan
- Reset: assert `rst`, then read addresses 0–3 → all return 0x00000000, and `irq`=0, `code`=0.
- Deferred commit:
  - Write SHADOW=0x12345678 with `imm`=0 → CTRL read bit2=1 and `code` stays 0.
  - Drive `v_sync` low at edge N → `code`=0x12345678 after edge N+2, FRAME reads 1, and bit2 reads 0.
- Immediate mode: write CTRL=0x1, then SHADOW=0xCAFEBABE → `code`=0xCAFEBABE one edge later, and `pending` is never set.
- Collision: write SHADOW=0xA5A5A5A5 on the exact edge where `frame_tick`=1, with an older pending value 0x11111111 → `code`=0xA5A5A5A5 and `pending`=0.
- IRQ:
  - With `irq_en`=1, a `frame_tick` sets `irq`=1. A FRAME write clears it.
  - A FRAME write coinciding with a `frame_tick` leaves `irq`=1.
- Wrap: preset the frame count near wrap by issuing 65535 ticks, then one more tick → FRAME reads 0. A long 800-cycle `v_sync` low pulse increments FRAME exactly once.
